// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: command encodings, slave-select bit and the
// master-queue FSM state encoding.
package xbar_pkg;

  localparam logic CMD_READ    = 1'b0;
  localparam logic CMD_WRITE   = 1'b1;
  localparam int   SLV_SEL_BIT = 31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RDATA = 2'd2
  } xbar_state_e;

endpackage

// File: rtl/xbar_sync_fifo.sv
// Single-clock show-ahead FIFO: head entry is visible on o_rdata while non-empty.
// Pushes while full are dropped, even if a pop happens in the same cycle.
module xbar_sync_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage has no reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/xbar_master_queue.sv
// Crossbar master port front end: queues client commands and replays them one
// at a time as req/ack transfers, returning read data and write completions.
module xbar_master_queue
  import xbar_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_cmd,
  input  logic [AW-1:0]            cmd_addr,
  input  logic [DW-1:0]            cmd_wdata,
  output logic [$clog2(DEPTH):0]   cmd_count,
  output logic                     rd_valid,
  output logic [DW-1:0]            rd_data,
  output logic                     wr_done,
  output logic                     master_req,
  output logic                     master_cmd,
  output logic [AW-1:0]            master_addr,
  output logic [DW-1:0]            master_wdata,
  input  logic [DW-1:0]            master_rdata,
  input  logic                     master_ack,
  output logic [1:0]               o_dbg_state
);

  localparam int FW = 1 + AW + DW;

  // Client side: a command is taken at a rising edge when cmd_valid && cmd_ready.
  // Bus side: master_req and its payload stay stable until master_ack is seen
  // high at a rising edge; read data arrives on master_rdata one cycle later.

  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic [FW-1:0] w_head;
  logic          w_head_cmd;
  logic [AW-1:0] w_head_addr;
  logic [DW-1:0] w_head_wdata;

  xbar_state_e   r_state,    w_state_nxt;
  logic          r_req,      w_req_nxt;
  logic          r_cmd,      w_cmd_nxt;
  logic [AW-1:0] r_addr,     w_addr_nxt;
  logic [DW-1:0] r_wdata,    w_wdata_nxt;
  logic          r_rd_valid, w_rd_valid_nxt;
  logic [DW-1:0] r_rd_data,  w_rd_data_nxt;
  logic          r_wr_done,  w_wr_done_nxt;

  xbar_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (cmd_valid),
    .i_wdata ({cmd_cmd, cmd_addr, cmd_wdata}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (cmd_count)
  );

  assign cmd_ready = ~w_full;
  assign {w_head_cmd, w_head_addr, w_head_wdata} = w_head;

  always_comb begin
    w_state_nxt    = r_state;
    w_req_nxt      = r_req;
    w_cmd_nxt      = r_cmd;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_rd_valid_nxt = 1'b0;
    w_rd_data_nxt  = r_rd_data;
    w_wr_done_nxt  = 1'b0;
    w_pop          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_nxt = 1'b0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_req_nxt   = 1'b1;
          w_cmd_nxt   = w_head_cmd;
          w_addr_nxt  = w_head_addr;
          w_wdata_nxt = w_head_wdata;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (master_ack) begin
          w_req_nxt = 1'b0;
          if (r_cmd == CMD_WRITE) begin
            w_wr_done_nxt = 1'b1;
            w_state_nxt   = ST_IDLE;
          end else begin
            w_state_nxt   = ST_RDATA;
          end
        end
      end
      ST_RDATA: begin
        w_rd_data_nxt  = master_rdata;
        w_rd_valid_nxt = 1'b1;
        w_state_nxt    = ST_IDLE;
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_req      <= 1'b0;
      r_cmd      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_wr_done  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_req      <= w_req_nxt;
      r_cmd      <= w_cmd_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_rd_data  <= w_rd_data_nxt;
      r_wr_done  <= w_wr_done_nxt;
    end
  end

  assign master_req   = r_req;
  assign master_cmd   = r_cmd;
  assign master_addr  = r_addr;
  assign master_wdata = r_wdata;
  assign rd_valid     = r_rd_valid;
  assign rd_data      = r_rd_data;
  assign wr_done      = r_wr_done;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_xbar_master_queue.sv
// Directed bench for xbar_master_queue: read/write transfers, fill and
// overflow, back-to-back spacing, stray ack and reset mid-transfer.
module tb_xbar_master_queue;
  import xbar_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   cmd_valid = 1'b0;
  logic                   cmd_ready;
  logic                   cmd_cmd = 1'b0;
  logic [AW-1:0]          cmd_addr = '0;
  logic [DW-1:0]          cmd_wdata = '0;
  logic [$clog2(DEPTH):0] cmd_count;
  logic                   rd_valid;
  logic [DW-1:0]          rd_data;
  logic                   wr_done;
  logic                   master_req;
  logic                   master_cmd;
  logic [AW-1:0]          master_addr;
  logic [DW-1:0]          master_wdata;
  logic [DW-1:0]          master_rdata = '0;
  logic                   master_ack = 1'b0;
  logic [1:0]             o_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] a;

  xbar_master_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_cmd      (cmd_cmd),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_count    (cmd_count),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .wr_done      (wr_done),
    .master_req   (master_req),
    .master_cmd   (master_cmd),
    .master_addr  (master_addr),
    .master_wdata (master_wdata),
    .master_rdata (master_rdata),
    .master_ack   (master_ack),
    .o_dbg_state  (o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic c, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    cmd_valid = 1'b1;
    cmd_cmd   = c;
    cmd_addr  = ad;
    cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Expects master_req already high for this transfer; holds ack low for
  // 'hold' cycles, then acks. Reads return garbage on the ack cycle and the
  // real data in the following cycle.
  task automatic do_xfer(input logic c, input logic [AW-1:0] ad, input logic [DW-1:0] d,
                         input logic [DW-1:0] rdat, input int hold);
    check("req_hi", master_req, 1);
    check("bus_cmd", master_cmd, c);
    check("bus_addr", master_addr, ad);
    check("bus_wdata", master_wdata, d);
    check("st_req", o_dbg_state, ST_REQ);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("req_hold", master_req, 1);
      check("addr_hold", master_addr, ad);
      check("wdata_hold", master_wdata, d);
    end
    master_ack   = 1'b1;
    master_rdata = 32'hDEAD_BEEF;
    tick();
    master_ack = 1'b0;
    check("req_drop", master_req, 0);
    if (c == CMD_WRITE) begin
      check("wr_done", wr_done, 1);
      check("no_rdv_on_wr", rd_valid, 0);
      check("st_idle_w", o_dbg_state, ST_IDLE);
    end else begin
      check("no_wrd_on_rd", wr_done, 0);
      check("rdv_early", rd_valid, 0);
      check("st_rdata", o_dbg_state, ST_RDATA);
      master_rdata = rdat;
      tick();
      master_rdata = '0;
      check("rd_valid", rd_valid, 1);
      check("rd_data", rd_data, rdat);
      check("req_low_rd", master_req, 0);
    end
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", master_req, 0);
    check("rst_cmd", master_cmd, 0);
    check("rst_addr", master_addr, 0);
    check("rst_wdata", master_wdata, 0);
    check("rst_rdv", rd_valid, 0);
    check("rst_rdata", rd_data, 0);
    check("rst_wrd", wr_done, 0);
    check("rst_cnt", cmd_count, 0);
    check("rst_state", o_dbg_state, ST_IDLE);
    rst_n = 1'b1;
    tick();
    check("rst_ready", cmd_ready, 1);

    // read from S0, ack three cycles after req
    push(CMD_READ, 32'h0000_ADD0, 32'h0);
    check("lat_cnt", cmd_count, 1);
    check("lat_req0", master_req, 0);
    tick();
    check("lat_req1", master_req, 1);
    check("pop_cnt", cmd_count, 0);
    do_xfer(CMD_READ, 32'h0000_ADD0, 32'h0, 32'hFEED_00C0, 2);
    tick();
    check("rdv_pulse", rd_valid, 0);
    check("rd_hold", rd_data, 32'hFEED_00C0);
    check("idle_req", master_req, 0);

    // write to S1
    push(CMD_WRITE, 32'h8000_ADD0, 32'h000F_EED0);
    tick();
    do_xfer(CMD_WRITE, 32'h8000_ADD0, 32'h000F_EED0, 32'h0, 2);
    tick();
    check("wrd_pulse", wr_done, 0);
    check("wr_no_rdv", rd_valid, 0);
    check("wr_idle_req", master_req, 0);

    // stray ack while idle
    master_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stray_state", o_dbg_state, ST_IDLE);
      check("stray_req", master_req, 0);
      check("stray_rdv", rd_valid, 0);
      check("stray_wrd", wr_done, 0);
      check("stray_cnt", cmd_count, 0);
    end
    master_ack = 1'b0;

    // fill: first entry goes to the bus, next four fill the FIFO, sixth dropped
    for (int i = 1; i <= 6; i++) begin
      push(CMD_WRITE, 32'(i) << 8, 32'(i));
      if (i == 5) begin
        check("full_cnt", cmd_count, 4);
        check("full_ready", cmd_ready, 0);
      end
    end
    check("ovf_cnt", cmd_count, 4);
    check("ovf_ready", cmd_ready, 0);
    for (int i = 1; i <= 5; i++) exp_q.push_back(32'(i) << 8);
    a = exp_q.pop_front();
    do_xfer(CMD_WRITE, a, a >> 8, 32'h0, 0);
    // full and popping in the same cycle: push must still be dropped
    cmd_valid = 1'b1;
    cmd_cmd   = CMD_WRITE;
    cmd_addr  = 32'h0000_0700;
    cmd_wdata = 32'h7;
    tick();
    cmd_valid = 1'b0;
    check("fullpop_cnt", cmd_count, 3);
    check("fullpop_ready", cmd_ready, 1);
    while (exp_q.size() > 0) begin
      a = exp_q.pop_front();
      do_xfer(CMD_WRITE, a, a >> 8, 32'h0, 0);
      tick();
    end
    check("drain_req", master_req, 0);
    check("drain_cnt", cmd_count, 0);
    repeat (3) tick();
    check("drain_quiet", master_req, 0);

    // back-to-back R, W, R with ack in the first req cycle
    push(CMD_READ, 32'h0000_0010, 32'h0);
    push(CMD_WRITE, 32'h8000_0020, 32'h55);
    push(CMD_READ, 32'h0000_0030, 32'h0);
    check("b2b_cnt", cmd_count, 2);
    do_xfer(CMD_READ, 32'h0000_0010, 32'h0, 32'hA000_0010, 0);
    tick();
    do_xfer(CMD_WRITE, 32'h8000_0020, 32'h55, 32'h0, 0);
    tick();
    do_xfer(CMD_READ, 32'h0000_0030, 32'h0, 32'hA000_0030, 0);
    tick();
    check("b2b_rdv_end", rd_valid, 0);
    check("b2b_req_end", master_req, 0);
    check("b2b_cnt_end", cmd_count, 0);

    // reset while a transfer is outstanding
    push(CMD_WRITE, 32'h8000_0040, 32'h7);
    tick();
    push(CMD_READ, 32'h0000_0050, 32'h0);
    push(CMD_READ, 32'h0000_0060, 32'h0);
    check("pre_rst_req", master_req, 1);
    check("pre_rst_cnt", cmd_count, 2);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_req", master_req, 0);
    check("arst_cnt", cmd_count, 0);
    check("arst_state", o_dbg_state, ST_IDLE);
    master_ack = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      master_ack = 1'b0;
      check("post_rst_req", master_req, 0);
      check("post_rst_rdv", rd_valid, 0);
      check("post_rst_wrd", wr_done, 0);
      check("post_rst_cnt", cmd_count, 0);
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
